// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32 opcode and funct3 constants for loads and stores
//   - FSM state enum (also exported on the debug port of lsu_stage)
//   - reset value of the forwarded next PC
//   - is_mem_op(): classifies an opcode as a memory access
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] RESET_NEXT_PC = 32'h3000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } lsu_state_e;

  function automatic logic is_mem_op(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: bundles the three handshake ports of the load/store unit.
//   EXU side  : exu_valid/exu_ready plus instruction payload
//   memory    : mem_req_* (request) and mem_resp_* (single-cycle response)
//   writeback : rd_valid/rd_ready plus result payload and trace fields
//
// Handshake rule for every valid/ready pair in this bundle: a transfer
// happens on a rising clock edge where valid and ready are both 1. Once a
// producer raises valid it keeps valid high and its payload unchanged until
// that transfer. ready may change freely and never depends on valid in the
// same cycle from the LSU side. mem_resp_valid has no ready: it is a
// one-cycle strobe per accepted request.
//
// Modports:
//   slave  - the view used by lsu_stage
//   master - the view of the surrounding pipeline/memory (e.g. a testbench)
interface lsu_if #(
  parameter int NUM_WIDTH = 64
);

  // EXU -> LSU
  logic                 exu_valid;
  logic                 exu_ready;
  logic [31:0]          exu_inst;
  logic [31:0]          exu_result;
  logic [31:0]          exu_store_data;
  logic [31:0]          exu_next_pc;
  logic [NUM_WIDTH-1:0] exu_num;

  // LSU <-> memory
  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic [31:0]          mem_req_addr;
  logic                 mem_req_wen;
  logic [31:0]          mem_req_wdata;
  logic [3:0]           mem_req_wstrb;
  logic                 mem_resp_valid;
  logic [31:0]          mem_resp_rdata;
  logic                 mem_resp_err;

  // LSU -> writeback
  logic                 rd_valid;
  logic                 rd_ready;
  logic [31:0]          wdata;
  logic [31:0]          lsu_to_wbu_inst;
  logic [31:0]          next_pc;
  logic [NUM_WIDTH-1:0] num;
  logic [31:0]          sim_lsu_addr;
  logic                 lsu_fault;

  modport slave (
    input  exu_valid, exu_inst, exu_result, exu_store_data, exu_next_pc, exu_num,
    output exu_ready,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
    output rd_valid, wdata, lsu_to_wbu_inst, next_pc, num, sim_lsu_addr, lsu_fault,
    input  rd_ready
  );

  modport master (
    output exu_valid, exu_inst, exu_result, exu_store_data, exu_next_pc, exu_num,
    input  exu_ready,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
    input  rd_valid, wdata, lsu_to_wbu_inst, next_pc, num, sim_lsu_addr, lsu_fault,
    output rd_ready
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
//   funct3, off   : access size/signedness and byte offset addr[1:0]
//   is_store      : 1 when the access is a store (enables wstrb/wdata)
//   store_data    : rs2 value for stores
//   rdata         : raw word returned by memory
//   wstrb, wdata  : lane strobes and lane-replicated store data
//   load_data     : selected and sign/zero-extended load result
//   misalign      : halfword at odd offset or word at non-zero offset
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Size is decoded from funct3[1:0]; funct3[2] only selects zero extension.
  always_comb begin
    wstrb    = 4'b0000;
    wdata    = 32'h0;
    misalign = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        if (is_store) begin
          wstrb = 4'b0001 << off;
          wdata = {4{store_data[7:0]}};
        end
      end
      2'b01: begin
        misalign = off[0];
        if (is_store) begin
          wstrb = 4'b0011 << off;
          wdata = {2{store_data[15:0]}};
        end
      end
      default: begin
        misalign = (off != 2'b00);
        if (is_store) begin
          wstrb = 4'b1111;
          wdata = store_data;
        end
      end
    endcase
  end

  always_comb begin
    byte_v = rdata[7:0];
    case (off)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
  end

  assign half_v = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  load_data = {24'h0, byte_v};
      F3_LH:   load_data = {{16{half_v[15]}}, half_v};
      F3_LHU:  load_data = {16'h0, half_v};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// lsu_stage: load/store unit between execute and writeback.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : lsu_if.slave - EXU accept port, single-outstanding
//                  memory request/response port, writeback result port
//   dbg_state    : current FSM state for observation
//
// One instruction is held at a time. Loads/stores go IDLE->REQ->WAIT->OUT,
// everything else (and misaligned accesses) goes IDLE->OUT directly.
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WIDTH  = 64
) (
  input  logic       clock,
  input  logic       reset,
  lsu_if.slave       bus,
  output lsu_state_e dbg_state
);

  lsu_state_e state_q, state_d;

  logic [31:0]           inst_q,    inst_d;
  logic [DATA_WIDTH-1:0] addr_q,    addr_d;
  logic [DATA_WIDTH-1:0] sdata_q,   sdata_d;
  logic [31:0]           next_pc_q, next_pc_d;
  logic [NUM_WIDTH-1:0]  num_q,     num_d;
  logic [31:0]           wdata_q,   wdata_d;
  logic [31:0]           sim_addr_q, sim_addr_d;
  logic                  fault_pulse;

  // Alignment logic sees the live EXU fields while idle (for the misalign
  // decision at capture) and the captured fields afterwards.
  logic        in_idle;
  logic [31:0] al_inst;
  logic [31:0] al_addr;
  logic [31:0] al_sdata;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_misalign;

  assign in_idle  = (state_q == ST_IDLE);
  assign al_inst  = in_idle ? bus.exu_inst       : inst_q;
  assign al_addr  = in_idle ? bus.exu_result     : addr_q;
  assign al_sdata = in_idle ? bus.exu_store_data : sdata_q;

  lsu_align u_align (
    .funct3     (al_inst[14:12]),
    .off        (al_addr[1:0]),
    .is_store   (al_inst[6:0] == OPC_STORE),
    .store_data (al_sdata),
    .rdata      (bus.mem_resp_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misalign   (al_misalign)
  );

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    next_pc_d   = next_pc_q;
    num_d       = num_q;
    wdata_d     = wdata_q;
    sim_addr_d  = sim_addr_q;
    fault_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.exu_valid) begin
          inst_d    = bus.exu_inst;
          addr_d    = bus.exu_result;
          sdata_d   = bus.exu_store_data;
          next_pc_d = bus.exu_next_pc;
          num_d     = bus.exu_num;
          if (is_mem_op(bus.exu_inst[6:0])) begin
            sim_addr_d = bus.exu_result;
            if (al_misalign) begin
              // No bus access: complete immediately with a zero result.
              fault_pulse = 1'b1;
              wdata_d     = 32'h0;
              state_d     = ST_OUT;
            end else begin
              state_d = ST_REQ;
            end
          end else begin
            sim_addr_d = 32'h0;
            wdata_d    = bus.exu_result;
            state_d    = ST_OUT;
          end
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.mem_resp_valid) begin
          state_d = ST_OUT;
          if (bus.mem_resp_err) begin
            fault_pulse = 1'b1;
            wdata_d     = 32'h0;
          end else if (inst_q[6:0] == OPC_STORE) begin
            wdata_d = 32'h0;
          end else begin
            wdata_d = al_load;
          end
        end
      end
      ST_OUT: begin
        if (bus.rd_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      inst_q     <= 32'h0;
      addr_q     <= '0;
      sdata_q    <= '0;
      next_pc_q  <= RESET_NEXT_PC;
      num_q      <= '0;
      wdata_q    <= 32'h0;
      sim_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      next_pc_q  <= next_pc_d;
      num_q      <= num_d;
      wdata_q    <= wdata_d;
      sim_addr_q <= sim_addr_d;
    end
  end

  assign bus.exu_ready       = in_idle;

  assign bus.mem_req_valid   = (state_q == ST_REQ);
  assign bus.mem_req_addr    = {addr_q[31:2], 2'b00};
  assign bus.mem_req_wen     = (inst_q[6:0] == OPC_STORE);
  assign bus.mem_req_wdata   = al_wdata;
  assign bus.mem_req_wstrb   = al_wstrb;

  assign bus.rd_valid        = (state_q == ST_OUT);
  assign bus.wdata           = wdata_q;
  assign bus.lsu_to_wbu_inst = inst_q;
  assign bus.next_pc         = next_pc_q;
  assign bus.num             = num_q;
  assign bus.sim_lsu_addr    = sim_addr_q;
  // Masked during reset so the pulse can never appear while state is stale.
  assign bus.lsu_fault       = fault_pulse & ~reset;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_stage.sv
module tb_lsu_stage;
  import lsu_pkg::*;

  logic       clock;
  logic       reset;
  lsu_state_e dbg_state;

  lsu_if #(.NUM_WIDTH(64)) bus ();

  lsu_stage #(.DATA_WIDTH(32), .NUM_WIDTH(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        is_mem;
    logic        misalign;
    logic        wen;
    logic [31:0] req_addr;
    logic [3:0]  wstrb;
    logic [31:0] req_wdata;
    logic [31:0] wdata;
    logic [31:0] sim_addr;
  } exp_t;

  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [31:0] rdata,
                                 input logic err);
    exp_t m;
    logic [6:0]  opc;
    logic [2:0]  f3;
    int          size;
    int          off;
    logic [31:0] sh;
    logic [31:0] v;
    opc  = inst[6:0];
    f3   = inst[14:12];
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off  = int'(addr % 4);
    m.is_mem   = (opc == 7'h03) || (opc == 7'h23);
    m.wen      = (opc == 7'h23);
    m.misalign = m.is_mem && ((addr % size) != 0);
    m.req_addr = addr - off;
    m.wstrb    = m.wen ? 4'(((1 << size) - 1) << off) : 4'h0;
    if (size == 1)      m.req_wdata = sdata[7:0] * 32'h0101_0101;
    else if (size == 2) m.req_wdata = sdata[15:0] * 32'h0001_0001;
    else                m.req_wdata = sdata;
    sh = rdata >> (8 * off);
    if (size == 1) begin
      v = sh & 32'hFF;
      if (!f3[2] && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2) begin
      v = sh & 32'hFFFF;
      if (!f3[2] && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    if (!m.is_mem)                          m.wdata = addr;
    else if (m.misalign || err || m.wen)    m.wdata = 32'h0;
    else                                    m.wdata = v;
    m.sim_addr = m.is_mem ? addr : 32'h0;
    return m;
  endfunction

  function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3);
    return {17'h0, f3, 5'd5, opc};
  endfunction

  // ---------------- driver tasks ----------------
  // Runs one instruction end to end; called and returns at a negedge.
  task automatic run_instr(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdata, input logic err,
                           input int req_stall, input int rd_stall, output logic [31:0] obs_wdata);
    exp_t        e;
    logic [31:0] npc;
    logic [63:0] nm;
    logic [31:0] exp_w;
    e   = model(inst, addr, sdata, rdata, err);
    npc = $urandom;
    nm  = {$urandom, $urandom};
    exp_q.push_back(e.wdata);

    chk({tag, ".exu_ready_idle"}, bus.exu_ready, 1'b1);
    bus.exu_inst       = inst;
    bus.exu_result     = addr;
    bus.exu_store_data = sdata;
    bus.exu_next_pc    = npc;
    bus.exu_num        = nm;
    bus.exu_valid      = 1'b1;
    #1;
    chk({tag, ".fault_capture"}, bus.lsu_fault, e.misalign);
    @(posedge clock);
    @(negedge clock);
    bus.exu_valid      = 1'b0;
    bus.exu_inst       = $urandom;
    bus.exu_result     = $urandom;
    bus.exu_store_data = $urandom;
    bus.exu_next_pc    = $urandom;

    if (e.is_mem && !e.misalign) begin
      for (int i = 0; i <= req_stall; i++) begin
        if (i > 0) @(negedge clock);
        chk({tag, ".req_valid"}, bus.mem_req_valid, 1'b1);
        chk({tag, ".req_addr"},  bus.mem_req_addr,  e.req_addr);
        chk({tag, ".req_wen"},   bus.mem_req_wen,   e.wen);
        chk({tag, ".req_wstrb"}, bus.mem_req_wstrb, e.wstrb);
        if (e.wen) chk({tag, ".req_wdata"}, bus.mem_req_wdata, e.req_wdata);
        chk({tag, ".exu_ready_busy"}, bus.exu_ready, 1'b0);
      end
      bus.mem_req_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.mem_req_ready = 1'b0;
      chk({tag, ".req_dropped"}, bus.mem_req_valid, 1'b0);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = rdata;
      bus.mem_resp_err   = err;
      #1;
      chk({tag, ".fault_resp"}, bus.lsu_fault, err);
      @(posedge clock);
      @(negedge clock);
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_err   = 1'b0;
      bus.mem_resp_rdata = $urandom;
    end

    for (int i = 0; i <= rd_stall; i++) begin
      if (i > 0) @(negedge clock);
      chk({tag, ".rd_valid"},   bus.rd_valid,        1'b1);
      chk({tag, ".wdata"},      bus.wdata,           e.wdata);
      chk({tag, ".inst"},       bus.lsu_to_wbu_inst, inst);
      chk({tag, ".next_pc"},    bus.next_pc,         npc);
      chk({tag, ".num"},        bus.num,             nm);
      chk({tag, ".sim_addr"},   bus.sim_lsu_addr,    e.sim_addr);
      chk({tag, ".no_req"},     bus.mem_req_valid,   1'b0);
      chk({tag, ".fault_idle"}, bus.lsu_fault,       1'b0);
      chk({tag, ".exu_ready_out"}, bus.exu_ready,    1'b0);
    end
    bus.rd_ready = 1'b1;
    obs_wdata = bus.wdata;
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_0000;
    chk({tag, ".sb_wdata"}, obs_wdata, exp_w);
    @(posedge clock);
    @(negedge clock);
    bus.rd_ready = 1'b0;
    chk({tag, ".rd_done"}, bus.rd_valid, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] w;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [2:0]  f3;
    int          kind;

    reset              = 1'b1;
    bus.exu_valid      = 1'b0;
    bus.exu_inst       = 32'h0;
    bus.exu_result     = 32'h0;
    bus.exu_store_data = 32'h0;
    bus.exu_next_pc    = 32'h0;
    bus.exu_num        = 64'h0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = 32'h0;
    bus.mem_resp_err   = 1'b0;
    bus.rd_ready       = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // reset state
    chk("rst.exu_ready", bus.exu_ready,       1'b1);
    chk("rst.rd_valid",  bus.rd_valid,        1'b0);
    chk("rst.req_valid", bus.mem_req_valid,   1'b0);
    chk("rst.fault",     bus.lsu_fault,       1'b0);
    chk("rst.inst",      bus.lsu_to_wbu_inst, 32'h0);
    chk("rst.wdata",     bus.wdata,           32'h0);
    chk("rst.next_pc",   bus.next_pc,         32'h3000_0000);
    chk("rst.num",       bus.num,             64'h0);
    chk("rst.sim_addr",  bus.sim_lsu_addr,    32'h0);

    // ALU op passes straight through
    run_instr("addi", mk_inst(7'h13, 3'b000), 32'h0000_1234, 32'h0, 32'h0, 1'b0, 0, 0, w);
    chk("addi.plan_wdata", w, 32'h0000_1234);

    run_instr("lb", mk_inst(7'h03, 3'b000), 32'h8000_0003, 32'h0, 32'h80FF_0000, 1'b0, 0, 0, w);
    chk("lb.plan_wdata", w, 32'hFFFF_FF80);
    run_instr("lbu", mk_inst(7'h03, 3'b100), 32'h8000_0003, 32'h0, 32'h80FF_0000, 1'b0, 0, 0, w);
    chk("lbu.plan_wdata", w, 32'h0000_0080);

    run_instr("sh", mk_inst(7'h23, 3'b001), 32'h8000_0002, 32'h0000_BEEF, 32'h0, 1'b0, 3, 0, w);
    chk("sh.plan_wdata", w, 32'h0);

    run_instr("lw_mis", mk_inst(7'h03, 3'b010), 32'h8000_0001, 32'h0, 32'h1234_5678, 1'b0, 0, 0, w);
    run_instr("lw_err", mk_inst(7'h03, 3'b010), 32'h8000_0004, 32'h0, 32'hCAFE_F00D, 1'b1, 0, 4, w);
    chk("lw_err.plan_wdata", w, 32'h0);

    // reset while waiting for the memory response
    bus.exu_inst   = mk_inst(7'h03, 3'b010);
    bus.exu_result = 32'h8000_0010;
    bus.exu_valid  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.exu_valid     = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.mem_req_ready = 1'b0;
    chk("rstwait.state_wait", dbg_state, ST_WAIT);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rstwait.state_idle", dbg_state, ST_IDLE);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h5555_AAAA;
    bus.mem_resp_err   = 1'b1;
    #1;
    chk("rstwait.fault", bus.lsu_fault, 1'b0);
    @(posedge clock);
    @(negedge clock);
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_err   = 1'b0;
    chk("rstwait.rd_valid",  bus.rd_valid,  1'b0);
    chk("rstwait.exu_ready", bus.exu_ready, 1'b1);
    chk("rstwait.state_end", dbg_state,     ST_IDLE);
    chk("rstwait.wdata",     bus.wdata,     32'h0);
    chk("rstwait.next_pc",   bus.next_pc,   32'h3000_0000);
    run_instr("post_rst", mk_inst(7'h33, 3'b000), 32'h0BAD_F00D, 32'h0, 32'h0, 1'b0, 0, 1, w);

    // randomized mix
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      addr = 32'h8000_0000 | 32'($urandom_range(0, 255));
      if (kind == 0) begin
        inst = mk_inst(($urandom_range(0, 1) == 0) ? 7'h13 : 7'h33, 3'($urandom_range(0, 7)));
        addr = $urandom;
      end else if (kind == 1) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
        inst = mk_inst(7'h03, f3);
      end else begin
        inst = mk_inst(7'h23, 3'($urandom_range(0, 2)));
      end
      run_instr($sformatf("rnd%0d", n), inst, addr, $urandom, $urandom,
                ($urandom_range(0, 7) == 0), $urandom_range(0, 2), $urandom_range(0, 2), w);
    end

    chk("sb.empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
